// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and ALU function codes.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int PC_W   = 32;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

endpackage

// File: rtl/exec_flow_unit_if.sv
// Execute-stage bus: operands and flow requests in, ALU result and PC values out.
interface exec_flow_unit_if;
    import cpu_pkg::*;

    logic              BUSYWAIT;
    logic [DATA_W-1:0] DATA1;
    logic [DATA_W-1:0] DATA2;
    logic [2:0]        ALUOP;
    logic              JUMP;
    logic              BRANCH;
    logic [7:0]        OFFSET;
    logic [DATA_W-1:0] RESULT;
    logic              ZERO;
    logic [PC_W-1:0]   PCPLUS4;
    logic [PC_W-1:0]   TARGET;
    logic              FLOWSEL;
    logic [PC_W-1:0]   PC;

    modport master (
        output BUSYWAIT, DATA1, DATA2, ALUOP, JUMP, BRANCH, OFFSET,
        input  RESULT, ZERO, PCPLUS4, TARGET, FLOWSEL, PC
    );

    modport slave (
        input  BUSYWAIT, DATA1, DATA2, ALUOP, JUMP, BRANCH, OFFSET,
        output RESULT, ZERO, PCPLUS4, TARGET, FLOWSEL, PC
    );

endinterface

// File: rtl/exec_alu.sv
// Combinational 8-bit ALU with ZERO flag; reserved function codes produce 0.
module exec_alu
    import cpu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] i_data1,
    input  logic [W-1:0] i_data2,
    input  logic [2:0]   i_aluop,
    output logic [W-1:0] o_result,
    output logic         o_zero
);

    logic [W-1:0] w_result;

    always_comb begin
        w_result = '0;
        case (i_aluop)
            ALU_FWD: w_result = i_data2;
            ALU_ADD: w_result = i_data1 + i_data2;
            ALU_AND: w_result = i_data1 & i_data2;
            ALU_OR:  w_result = i_data1 | i_data2;
            default: w_result = '0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == '0);

endmodule

// File: rtl/exec_flow_unit.sv
// Execute stage: ALU, branch/jump select, target adder and the PC register.
module exec_flow_unit #(
    parameter int                  DATA_W   = cpu_pkg::DATA_W,
    parameter int                  PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0]     PC_RESET = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    exec_flow_unit_if.slave  bus
);

    logic [DATA_W-1:0] w_result;
    logic              w_zero;
    logic              w_flowsel;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pcplus4;
    logic [PC_W-1:0]   w_offset_ext;
    logic [PC_W-1:0]   w_target;
    logic [PC_W-1:0]   w_next_pc;

    exec_alu #(.W(DATA_W)) u_alu (
        .i_data1  (bus.DATA1),
        .i_data2  (bus.DATA2),
        .i_aluop  (bus.ALUOP),
        .o_result (w_result),
        .o_zero   (w_zero)
    );

    // OFFSET counts words: sign-extend, then scale by 4 bytes.
    assign w_offset_ext = {{(PC_W-10){bus.OFFSET[7]}}, bus.OFFSET, 2'b00};
    assign w_pcplus4    = r_pc + PC_W'(4);
    assign w_target     = w_pcplus4 + w_offset_ext;
    assign w_flowsel    = bus.JUMP | (bus.BRANCH & w_zero);
    assign w_next_pc    = w_flowsel ? w_target : w_pcplus4;

    // Reset outranks a memory stall so a reset mid-stall still clears the PC.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc <= PC_RESET;
        end else if (!bus.BUSYWAIT) begin
            r_pc <= w_next_pc;
        end
    end

    assign bus.RESULT  = w_result;
    assign bus.ZERO    = w_zero;
    assign bus.PCPLUS4 = w_pcplus4;
    assign bus.TARGET  = w_target;
    assign bus.FLOWSEL = w_flowsel;
    assign bus.PC      = r_pc;

endmodule

// File: tb/tb_exec_flow_unit.sv
// Self-checking bench for exec_flow_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_exec_flow_unit;
    import cpu_pkg::*;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    exec_flow_unit_if ef_if();

    exec_flow_unit #(
        .DATA_W   (8),
        .PC_W     (32),
        .PC_RESET (32'h0000_0000)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ef_if)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_pc = 32'h0;

    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int s;
        case (op)
            3'd0: return b;
            3'd1: begin s = (int'(a) + int'(b)) % 256; return 8'(s); end
            3'd2: return a & b;
            3'd3: return a | b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [7:0] off);
        longint o;
        longint t;
        o = longint'($signed(off));
        t = longint'(pc) + 64'd4 + 4 * o;
        return t[31:0];
    endfunction

    task automatic set_in(input logic busy, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [2:0] op, input logic j, input logic br, input logic [7:0] off);
        ef_if.BUSYWAIT = busy;
        ef_if.DATA1    = d1;
        ef_if.DATA2    = d2;
        ef_if.ALUOP    = op;
        ef_if.JUMP     = j;
        ef_if.BRANCH   = br;
        ef_if.OFFSET   = off;
        #1;
    endtask

    // One clock edge; the model PC follows the reset > stall > next-PC rule.
    task automatic edge_step(input logic rst);
        logic flow;
        flow = ef_if.JUMP | (ef_if.BRANCH & (ref_alu(ef_if.ALUOP, ef_if.DATA1, ef_if.DATA2) == 8'h00));
        if (rst)                 m_pc = 32'h0;
        else if (ef_if.BUSYWAIT) m_pc = m_pc;
        else if (flow)           m_pc = ref_target(m_pc, ef_if.OFFSET);
        else                     m_pc = m_pc + 32'd4;
        RESET = rst;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        set_in(1'b1, 8'h00, 8'h01, ALU_ADD, 1'b0, 1'b0, 8'h00);
        edge_step(1'b1);
        n_cmp++; if (ef_if.PC !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h expected %h", ef_if.PC, 32'd0); end
        n_cmp++; if (ef_if.PCPLUS4 !== 32'd4) begin n_err++; $display("FAIL reset_pcplus4: got %h expected %h", ef_if.PCPLUS4, 32'd4); end
        set_in(1'b0, 8'h00, 8'h01, ALU_ADD, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) edge_step(1'b0);
        n_cmp++; if (ef_if.PC !== 32'd12) begin n_err++; $display("FAIL free_run_pc: got %h expected %h", ef_if.PC, 32'd12); end
        $display("test_reset: pc=%h", ef_if.PC);
    endtask

    task automatic test_alu_sweep();
        logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        logic [7:0] exps [5] = '{8'h3C, 8'h4B, 8'h0C, 8'h3F, 8'h00};
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 8'h0F, 8'h3C, ops[i], 1'b0, 1'b0, 8'h00);
            n_cmp++; if (ef_if.RESULT !== exps[i]) begin n_err++; $display("FAIL alu_op%0d_result: got %h expected %h", ops[i], ef_if.RESULT, exps[i]); end
            n_cmp++; if (ef_if.ZERO !== (exps[i] == 8'h00)) begin n_err++; $display("FAIL alu_op%0d_zero: got %b expected %b", ops[i], ef_if.ZERO, exps[i] == 8'h00); end
            $display("test_alu_sweep: op=%b result=%h zero=%b", ops[i], ef_if.RESULT, ef_if.ZERO);
        end
        set_in(1'b0, 8'hFF, 8'h01, ALU_ADD, 1'b0, 1'b0, 8'h00);
        n_cmp++; if (ef_if.RESULT !== 8'h00) begin n_err++; $display("FAIL alu_add_wrap_result: got %h expected %h", ef_if.RESULT, 8'h00); end
        n_cmp++; if (ef_if.ZERO !== 1'b1) begin n_err++; $display("FAIL alu_add_wrap_zero: got %b expected %b", ef_if.ZERO, 1'b1); end
        $display("test_alu_sweep: add wrap result=%h zero=%b", ef_if.RESULT, ef_if.ZERO);
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            set_in(1'b0, 8'h00, 8'h01, ALU_ADD, 1'b0, 1'b0, 8'h00);
            edge_step(1'b1);
            edge_step(1'b0);
            edge_step(1'b0);
            set_in(1'b0, 8'h05, (k == 0) ? 8'hFB : 8'hFC, ALU_ADD, 1'b0, 1'b1, 8'h02);
            n_cmp++; if (ef_if.ZERO !== (k == 0)) begin n_err++; $display("FAIL beq%0d_zero: got %b expected %b", k, ef_if.ZERO, k == 0); end
            n_cmp++; if (ef_if.FLOWSEL !== (k == 0)) begin n_err++; $display("FAIL beq%0d_flowsel: got %b expected %b", k, ef_if.FLOWSEL, k == 0); end
            n_cmp++; if (ef_if.TARGET !== 32'd20) begin n_err++; $display("FAIL beq%0d_target: got %h expected %h", k, ef_if.TARGET, 32'd20); end
            edge_step(1'b0);
            n_cmp++; if (ef_if.PC !== ((k == 0) ? 32'd20 : 32'd12)) begin n_err++; $display("FAIL beq%0d_pc: got %h expected %h", k, ef_if.PC, (k == 0) ? 32'd20 : 32'd12); end
            $display("test_beq: case=%0d flowsel=%b pc=%h", k, ef_if.FLOWSEL, ef_if.PC);
        end
    endtask

    task automatic test_jump();
        set_in(1'b0, 8'h00, 8'h01, ALU_ADD, 1'b0, 1'b0, 8'h00);
        edge_step(1'b1);
        for (int i = 0; i < 4; i++) edge_step(1'b0);
        set_in(1'b0, 8'h01, 8'h01, ALU_ADD, 1'b1, 1'b0, 8'hFD);
        n_cmp++; if (ef_if.TARGET !== 32'd8) begin n_err++; $display("FAIL jump_target: got %h expected %h", ef_if.TARGET, 32'd8); end
        n_cmp++; if (ef_if.FLOWSEL !== 1'b1) begin n_err++; $display("FAIL jump_flowsel: got %b expected %b", ef_if.FLOWSEL, 1'b1); end
        edge_step(1'b0);
        n_cmp++; if (ef_if.PC !== 32'd8) begin n_err++; $display("FAIL jump_pc: got %h expected %h", ef_if.PC, 32'd8); end
        $display("test_jump: pc=%h", ef_if.PC);
    endtask

    task automatic test_stall();
        set_in(1'b1, 8'h00, 8'h00, ALU_ADD, 1'b1, 1'b1, 8'h02);
        for (int i = 0; i < 3; i++) begin
            edge_step(1'b0);
            n_cmp++; if (ef_if.PC !== 32'd8) begin n_err++; $display("FAIL stall%0d_pc: got %h expected %h", i, ef_if.PC, 32'd8); end
            $display("test_stall: edge=%0d pc=%h", i, ef_if.PC);
        end
        set_in(1'b0, 8'h00, 8'h00, ALU_ADD, 1'b1, 1'b1, 8'h02);
        edge_step(1'b0);
        n_cmp++; if (ef_if.PC !== 32'd20) begin n_err++; $display("FAIL stall_release_pc: got %h expected %h", ef_if.PC, 32'd20); end
        set_in(1'b1, 8'h00, 8'h00, ALU_ADD, 1'b1, 1'b0, 8'h02);
        edge_step(1'b1);
        n_cmp++; if (ef_if.PC !== 32'd0) begin n_err++; $display("FAIL reset_mid_stall_pc: got %h expected %h", ef_if.PC, 32'd0); end
        $display("test_stall: release then reset pc=%h", ef_if.PC);
    endtask

    task automatic test_boundary();
        set_in(1'b0, 8'h01, 8'h01, ALU_ADD, 1'b1, 1'b0, 8'hFE);
        n_cmp++; if (ef_if.TARGET !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_low_target: got %h expected %h", ef_if.TARGET, 32'hFFFF_FFFC); end
        edge_step(1'b0);
        set_in(1'b0, 8'h01, 8'h01, ALU_ADD, 1'b0, 1'b0, 8'h00);
        n_cmp++; if (ef_if.PCPLUS4 !== 32'h0) begin n_err++; $display("FAIL wrap_high_pcplus4: got %h expected %h", ef_if.PCPLUS4, 32'h0); end
        edge_step(1'b0);
        n_cmp++; if (ef_if.PC !== 32'h0) begin n_err++; $display("FAIL wrap_high_pc: got %h expected %h", ef_if.PC, 32'h0); end
        set_in(1'b0, 8'h01, 8'h01, ALU_ADD, 1'b1, 1'b0, 8'h7F);
        edge_step(1'b0);
        edge_step(1'b0);
        n_cmp++; if (ef_if.PC !== 32'd1024) begin n_err++; $display("FAIL far_jump_pc: got %h expected %h", ef_if.PC, 32'd1024); end
        set_in(1'b0, 8'h01, 8'h01, ALU_ADD, 1'b1, 1'b0, 8'h80);
        n_cmp++; if (ef_if.TARGET !== 32'd516) begin n_err++; $display("FAIL offset_min_target: got %h expected %h", ef_if.TARGET, 32'd516); end
        set_in(1'b0, 8'h01, 8'h01, ALU_ADD, 1'b1, 1'b0, 8'hFF);
        n_cmp++; if (ef_if.TARGET !== 32'd1024) begin n_err++; $display("FAIL offset_ff_target: got %h expected %h", ef_if.TARGET, 32'd1024); end
        $display("test_boundary: pc=%h target=%h", ef_if.PC, ef_if.TARGET);
    endtask

    task automatic test_random();
        logic [7:0]  d1, d2, exp_res;
        logic [2:0]  op;
        logic        j, br, busy, rst, exp_zero, exp_flow;
        logic [7:0]  off;
        logic [31:0] exp_p4, exp_tgt;
        for (int i = 0; i < 300; i++) begin
            d1   = 8'($urandom);
            d2   = ($urandom_range(0, 3) == 0) ? 8'(256 - int'(d1)) : 8'($urandom);
            op   = 3'($urandom_range(0, 7));
            j    = ($urandom_range(0, 7) == 0);
            br   = ($urandom_range(0, 2) == 0);
            busy = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 31) == 0);
            off  = 8'($urandom);
            set_in(busy, d1, d2, op, j, br, off);
            exp_res  = ref_alu(op, d1, d2);
            exp_zero = (exp_res == 8'h00);
            exp_flow = j || (br && exp_zero);
            exp_p4   = m_pc + 32'd4;
            exp_tgt  = ref_target(m_pc, off);
            n_cmp++;
            if ({ef_if.RESULT, ef_if.ZERO, ef_if.FLOWSEL, ef_if.PCPLUS4, ef_if.TARGET} !==
                {exp_res, exp_zero, exp_flow, exp_p4, exp_tgt}) begin
                n_err++;
                $display("FAIL rand%0d_comb: got res=%h z=%b f=%b p4=%h tgt=%h expected res=%h z=%b f=%b p4=%h tgt=%h",
                         i, ef_if.RESULT, ef_if.ZERO, ef_if.FLOWSEL, ef_if.PCPLUS4, ef_if.TARGET,
                         exp_res, exp_zero, exp_flow, exp_p4, exp_tgt);
            end
            edge_step(rst);
            n_cmp++; if (ef_if.PC !== m_pc) begin n_err++; $display("FAIL rand%0d_pc: got %h expected %h", i, ef_if.PC, m_pc); end
            $display("test_random: %0d op=%b d1=%h d2=%h j=%b b=%b busy=%b rst=%b off=%h pc=%h",
                     i, op, d1, d2, j, br, busy, rst, off, ef_if.PC);
        end
    endtask

    initial begin
        set_in(1'b0, 8'h00, 8'h00, ALU_FWD, 1'b0, 1'b0, 8'h00);
        @(negedge CLK);
        test_reset();
        test_alu_sweep();
        test_beq();
        test_jump();
        test_stall();
        test_boundary();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_flow_unit.md
Name: exec_flow_unit

Overview:
- Execute-stage datapath slice of the 8-bit single-cycle CPU.
- Contains the 8-bit ALU with ZERO flag, the flow-control select logic, the jump/branch target adder, and the PC register with PC+4 incrementer.
- Sits between the register file / operand muxes and instruction memory. Produces the ALU result (used for register writeback and as the data-memory address) and the next PC.

Parameters:
- DATA_W, 8, ALU operand/result width.
- PC_W, 32, program counter width.
- PC_RESET, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- BUSYWAIT  in  1  memory stall; high holds the PC.
- DATA1  in  DATA_W  ALU operand 1 (register value).
- DATA2  in  DATA_W  ALU operand 2 (register, negated register, or immediate; pre-selected upstream).
- ALUOP  in  3  ALU function select.
- JUMP  in  1  unconditional jump request.
- BRANCH  in  1  branch-if-zero request.
- OFFSET  in  8  signed word offset from instruction bits [23:16].
- RESULT  out  DATA_W  ALU result.
- ZERO  out  1  high when RESULT == 0.
- PCPLUS4  out  PC_W  PC + 4.
- TARGET  out  PC_W  jump/branch target.
- FLOWSEL  out  1  high when the next PC is TARGET.
- PC  out  PC_W  current program counter (registered).

Behaviour:
- ALU (combinational):
  - ALUOP 000 FORWARD: RESULT = DATA2.
  - 001 ADD: RESULT = DATA1 + DATA2, modulo 2^8, carry discarded.
  - 010 AND: bitwise AND.
  - 011 OR: bitwise OR.
  - 100–111 reserved: RESULT = 0.
- ZERO = (RESULT == 0), for every ALUOP including FORWARD and the reserved codes.
- Subtraction (sub/beq) is done upstream by feeding the two's complement into DATA2 with ALUOP = 001. Equal operands therefore give ZERO = 1.
- FLOWSEL = JUMP | (BRANCH & ZERO), combinational. JUMP and BRANCH both high: FLOWSEL = 1.
- PCPLUS4 = PC + 4, modulo 2^32.
- TARGET = PCPLUS4 + (sign_extend(OFFSET) << 2), modulo 2^32.
  - OFFSET 8'hFF gives TARGET = PC.
  - OFFSET 8'h80 gives PCPLUS4 − 512.
  - Wrap-around at 0 and at 2^32 is silent.
- Next PC = FLOWSEL ? TARGET : PCPLUS4.
- PC register, on the rising CLK edge, in priority order:
  - RESET = 1: PC <= PC_RESET (reset dominates BUSYWAIT).
  - else BUSYWAIT = 1: PC holds its value.
  - else: PC <= next PC.
- Reset values:
  - PC = PC_RESET.
  - All other outputs are combinational functions of the inputs and the PC; after reset PCPLUS4 = 4.
  - A reset asserted mid-stall clears the PC on the same edge.
- Latency:
  - ALU, ZERO, FLOWSEL and TARGET settle within the cycle.
  - PC updates one edge after its inputs are valid.
  - No internal delays (#) in the synthesizable RTL.
- BUSYWAIT does not affect the combinational outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - ALUOP constants: ALU_FWD = 3'b000, ALU_ADD = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011.
  - Width constants DATA_W and PC_W.
- One sub-module, exec_alu, containing the ALU and the ZERO flag.
- Flow-control logic, target adder and PC register stay inline in exec_flow_unit.

Test Plan:
- RESET = 1 for one edge, with BUSYWAIT = 1 -> PC = 0, PCPLUS4 = 4. Then three free edges (JUMP = BRANCH = 0) -> PC = 12.
- ALU sweep, DATA1 = 8'h0F, DATA2 = 8'h3C:
  - FWD -> 3C.
  - ADD -> 4B.
  - AND -> 0C.
  - OR -> 3F.
  - ALUOP = 3'b101 -> 00 with ZERO = 1.
  - ADD with DATA1 = FF, DATA2 = 01 -> 00, ZERO = 1.
- beq taken, PC = 8: DATA1 = 5, DATA2 = 8'hFB, ALUOP = ADD, BRANCH = 1, OFFSET = 8'h02 -> ZERO = 1, FLOWSEL = 1, TARGET = 20, PC = 20 after the edge. Same with DATA2 = 8'hFC -> FLOWSEL = 0, PC = 12.
- Jump backward, PC = 16: JUMP = 1, OFFSET = 8'hFD -> TARGET = 8, PC = 8 after the edge, regardless of ZERO.
- Stall, PC = 8: BUSYWAIT = 1 for 3 edges with JUMP = 1 -> PC stays 8. BUSYWAIT low -> PC takes TARGET on the next edge.
- Boundary: PC = 32'hFFFF_FFFC with no jump/branch -> PC = 0 after the edge. Separately, OFFSET = 8'h80 at PC = 1024 -> TARGET = 516.
